mem_line_server: RTL



---
 rtl/mem_line_server_pkg.sv | 29 ++
 rtl/mem_line_server_array.sv | 31 +++
 rtl/mem_line_server.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_line_server_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_pkg                                                          |
// | Shared state encoding and defaults for the memory line server    |
// | and the cache controller that drives it.                         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mem_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_READ_LAT  = 3;
  localparam int DEF_WRITE_LAT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10,
    END  = 2'b11
  } mem_state_e;

  // Wait-counter preload.
  // A value of zero means the request goes straight to RESP.
  function automatic logic [3:0] lat_load(input logic we, input int rd_lat, input int wr_lat);
    return we ? 4'(wr_lat - 1) : 4'(rd_lat - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_line_server_array.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_array                                                        |
// | Single-port synchronous RAM, 2**ADDR_W x DATA_W, read-first,     |
// | registered read data, contents not reset.                        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] wdat,
  output logic [DATA_W-1:0] rdat
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[adr] <= wdat;
    end
    rdat <= mem[adr];
  end

endmodule
`default_nettype wire

// File: rtl/mem_line_server.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_line_server                                                  |
// | Main-memory slave for the cache controller: one line per bus     |
// | cycle, acked after READ_LAT / WRITE_LAT clock edges.             |
// | Optional macro MEM_ERR_EN adds error termination at adr >= LIMIT.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mem_line_server
  import mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int READ_LAT  = DEF_READ_LAT,
  parameter int WRITE_LAT = DEF_WRITE_LAT
`ifdef MEM_ERR_EN
  ,
  parameter int LIMIT     = 2**ADDR_W - 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cyc_m2s,
  input  logic              we_m2s,
  input  logic [ADDR_W-1:0] adr_m2s,
  input  logic [DATA_W-1:0] dat_m2s,
  output logic [DATA_W-1:0] dat_mem_o,
  output logic              ack_mem_o,
  output logic              err_mem_o
);

  mem_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic              req_bad;
  logic [DATA_W-1:0] rdat;

`ifdef MEM_ERR_EN
  assign req_bad   = ({1'b0, adr_q} >= (ADDR_W+1)'(LIMIT));
  assign err_mem_o = err_q;
`else
  assign req_bad   = 1'b0;
  assign err_mem_o = 1'b0;
`endif

  // The RAM sees the registered address throughout, so the word read at
  // the edge leaving RESP lines up with ack_q rising.
  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .adr  (adr_q),
    .wdat (dat_q),
    .rdat (rdat)
  );

  assign ack_mem_o = ack_q;
  assign dat_mem_o = (ack_q && !we_q) ? rdat : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cyc_m2s) begin
          adr_d   = adr_m2s;
          we_d    = we_m2s;
          dat_d   = dat_m2s;
          cnt_d   = lat_load(we_m2s, READ_LAT, WRITE_LAT);
          state_d = (cnt_d != 4'd0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!cyc_m2s) begin
          state_d = IDLE;
        end else begin
          if (cnt_q == 4'd1) begin
            state_d = RESP;
          end
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = END;
        ack_d   = !req_bad;
        err_d   = req_bad;
        mem_we  = we_q && !req_bad;
      end
      END: begin
        if (!cyc_m2s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire
